// File: rtl/reg_transfer_ctrl.sv
// reg_transfer_ctrl: upstream control for a bank of four WIDTH-bit registers.
// Drives a shared data bus and a one-hot load vector to perform MOVE, INC,
// CLR and SWAP transfers, one request at a time. SWAP goes through an
// internal temp register over two load cycles.
// Optional build macro XFER_COUNT_EN adds an 8-bit saturating XFER_CNT
// output counting completed operations.
module reg_transfer_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [1:0]       SRC,
  input  logic [1:0]       DST,
  input  logic [WIDTH-1:0] Q0,
  input  logic [WIDTH-1:0] Q1,
  input  logic [WIDTH-1:0] Q2,
  input  logic [WIDTH-1:0] Q3,
  output logic [WIDTH-1:0] BUS,
  output logic [3:0]       LOAD,
  output logic             BUSY,
  output logic             DONE
`ifdef XFER_COUNT_EN
  ,
  output logic [7:0]       XFER_CNT
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, SWAP2, FIN} state_t;
  typedef enum logic [1:0] {OP_MOVE, OP_INC, OP_CLR, OP_SWAP} op_t;

  state_t           state, state_next;
  op_t              op_q;
  logic [1:0]       src_q, dst_q;
  logic [WIDTH-1:0] tmp;
  logic [WIDTH-1:0] q [4];

  assign q[0] = Q0;
  assign q[1] = Q1;
  assign q[2] = Q2;
  assign q[3] = Q3;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // State register, request latch and swap temp capture.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      op_q  <= OP_MOVE;
      src_q <= '0;
      dst_q <= '0;
      tmp   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && START) begin
        op_q  <= op_t'(OP);
        src_q <= SRC;
        dst_q <= DST;
      end
      if (state == EXEC && op_q == OP_SWAP) tmp <= q[src_q];
    end
  end

  // Next-state and Moore output decode from state and latched request.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    BUS        = '0;
    LOAD       = 4'b0000;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    case (state)
      IDLE: if (START) state_next = EXEC;
      EXEC: begin
        BUSY = 1'b1;
        case (op_q)
          OP_MOVE: begin
            BUS        = q[src_q];
            LOAD       = onehot(dst_q);
            state_next = FIN;
          end
          OP_INC: begin
            BUS        = q[src_q] + WIDTH'(1);
            LOAD       = onehot(dst_q);
            state_next = FIN;
          end
          OP_CLR: begin
            BUS        = '0;
            LOAD       = onehot(dst_q);
            state_next = FIN;
          end
          OP_SWAP: begin
            BUS        = q[dst_q];
            LOAD       = onehot(src_q);
            state_next = SWAP2;
          end
          default: state_next = FIN;
        endcase
      end
      SWAP2: begin
        BUSY       = 1'b1;
        BUS        = tmp;
        LOAD       = onehot(dst_q);
        state_next = FIN;
      end
      FIN: begin
        DONE       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef XFER_COUNT_EN
  // Completed-operation counter, saturating at 8'hFF.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                             XFER_CNT <= 8'h00;
    else if (state == FIN && XFER_CNT != 8'hFF) XFER_CNT <= XFER_CNT + 8'h01;
  end
`endif

endmodule
